// File: rtl/kgp_fetch_pkg.sv
// rtl/kgp_fetch_pkg.sv - shared types and constants for the instruction fetch unit
package kgp_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_DRAIN,
        ST_HOLD,
        ST_ERR
    } fetch_state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    localparam int DEFAULT_MAX_WAIT = 16;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory read bus (level req held until ack)
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/fetch_wait_timer.sv
// rtl/fetch_wait_timer.sv - counts unacknowledged request cycles, flags the MAX_WAIT-th one
module fetch_wait_timer #(
    parameter int MAX_WAIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != CNT_W'(MAX_WAIT))) begin
            count <= count + CNT_W'(1);
        end
    end

    // Count holds the cycles already waited, so the current cycle is number count+1.
    assign expired = enable && (count == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch sequencer: PC -> memory read -> registered instruction to decode
module instr_fetch_unit
    import kgp_fetch_pkg::*;
#(
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              pc_valid,
    output logic              pc_adv,
    instr_fetch_unit_if.master mem,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              flush,
    output logic              fetch_err,
    output logic [1:0]        err_code
);
    fetch_state_t      state;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic              timer_clear;
    logic              timer_en;
    logic              timer_expired;

    assign mem.mem_req  = req_q;
    assign mem.mem_addr = addr_q;

    assign timer_clear = (state == ST_IDLE);
    assign timer_en    = ((state == ST_REQ) || (state == ST_DRAIN)) && !mem.mem_ack;

    // instr_valid is high exactly in HOLD, so this is the decode acceptance.
    assign pc_adv = instr_valid && instr_ready && !flush;

    fetch_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            req_q       <= 1'b0;
            addr_q      <= '0;
            instr_valid <= 1'b0;
            instr_out   <= '0;
            instr_pc    <= '0;
            fetch_err   <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pc_valid) begin
                        if (pc_in[1:0] == 2'b00) begin
                            addr_q <= pc_in;
                            req_q  <= 1'b1;
                            state  <= ST_REQ;
                        end else begin
                            fetch_err <= 1'b1;
                            err_code  <= ERR_MISALIGN;
                            state     <= ST_ERR;
                        end
                    end
                end
                // Ack beats timeout, timeout beats flush.
                ST_REQ: begin
                    if (mem.mem_ack) begin
                        req_q <= 1'b0;
                        if (flush) begin
                            state <= ST_IDLE;
                        end else begin
                            instr_out   <= mem.mem_rdata;
                            instr_pc    <= addr_q;
                            instr_valid <= 1'b1;
                            state       <= ST_HOLD;
                        end
                    end else if (timer_expired) begin
                        req_q     <= 1'b0;
                        fetch_err <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                        state     <= ST_ERR;
                    end else if (flush) begin
                        state <= ST_DRAIN;
                    end
                end
                // The request cannot be withdrawn; wait out the ack and drop the data.
                ST_DRAIN: begin
                    if (mem.mem_ack) begin
                        req_q <= 1'b0;
                        state <= ST_IDLE;
                    end else if (timer_expired) begin
                        req_q     <= 1'b0;
                        fetch_err <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                        state     <= ST_ERR;
                    end
                end
                ST_HOLD: begin
                    if (flush || instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    state <= ST_ERR;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit with a delay-configurable memory
module tb_instr_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in = '0;
    logic        pc_valid = 1'b0;
    logic        pc_adv;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        flush = 1'b0;
    logic        fetch_err;
    logic [1:0]  err_code;

    instr_fetch_unit_if #(.ADDR_W(32)) mem_bus ();

    instr_fetch_unit #(
        .MAX_WAIT (16),
        .ADDR_W   (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_in),
        .pc_valid    (pc_valid),
        .pc_adv      (pc_adv),
        .mem         (mem_bus),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .flush       (flush),
        .fetch_err   (fetch_err),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    exp_t        sb_q[$];
    int          adv_cycles[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc_n = 0;
    int          adv_cnt = 0;
    int          wait_cnt = 0;
    int          mem_delay = 0;
    int          last_req_len = 0;
    bit          mem_hang = 0;
    bit          pv_force = 0;
    bit          rst_v = 1;
    bit          rdy_v = 0;
    bit          flush_v = 0;
    logic [31:0] pc_reg = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc  = pc;
        e.ins = pc + 32'h100;
        sb_q.push_back(e);
    endtask

    task automatic mem_model();
        if (mem_bus.mem_req) begin
            if (sb_q.size() != 0) check("mem_addr", mem_bus.mem_addr, sb_q[0].pc);
            if (!mem_hang && (wait_cnt == mem_delay)) begin
                mem_bus.mem_ack   = 1'b1;
                mem_bus.mem_rdata = mem_bus.mem_addr + 32'h100;
                last_req_len      = wait_cnt + 1;
            end else begin
                mem_bus.mem_ack   = 1'b0;
                mem_bus.mem_rdata = 32'hdead_beef;
            end
            wait_cnt++;
        end else begin
            mem_bus.mem_ack   = 1'b0;
            mem_bus.mem_rdata = '0;
            wait_cnt          = 0;
        end
    endtask

    task automatic monitor();
        logic exp_adv;
        exp_adv = instr_valid && instr_ready && !flush;
        check("pc_adv_rule", pc_adv, exp_adv);
        if (pc_adv) begin
            adv_cnt++;
            adv_cycles.push_back(cyc_n);
            pc_reg = pc_reg + 32'd4;
        end
        if (instr_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", instr_valid, 1'b0);
            end else begin
                check("instr_pc", instr_pc, sb_q[0].pc);
                check("instr_out", instr_out, sb_q[0].ins);
                if (instr_ready || flush) void'(sb_q.pop_front());
            end
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are checked 2ns after it.
    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
        rst         = rst_v;
        instr_ready = rdy_v;
        flush       = flush_v;
        mem_model();
        pc_valid    = pv_force || (sb_q.size() != 0);
        pc_in       = pc_reg;
        #1;
        monitor();
    endtask

    task automatic run_until_drained(input int budget);
        int n;
        n = 0;
        while ((sb_q.size() != 0) && (n < budget)) begin
            cyc();
            n++;
        end
        check("drain_budget", sb_q.size(), 0);
    endtask

    task automatic wait_req(input int budget);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!mem_bus.mem_req && (n < budget));
        check("req_seen", mem_bus.mem_req, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"}, mem_bus.mem_req, 0);
        check({tag, "_mem_addr"}, mem_bus.mem_addr, 0);
        check({tag, "_instr_valid"}, instr_valid, 0);
        check({tag, "_instr_out"}, instr_out, 0);
        check({tag, "_instr_pc"}, instr_pc, 0);
        check({tag, "_pc_adv"}, pc_adv, 0);
        check({tag, "_fetch_err"}, fetch_err, 0);
        check({tag, "_err_code"}, err_code, 0);
    endtask

    task automatic pulse_reset();
        rst_v = 1;
        cyc();
        rst_v = 0;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int reqc;
        int adv0;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;

        // Reset state
        cyc();
        pulse_reset();
        check_all_zero("reset");

        // Zero-wait memory, three back-to-back fetches
        rdy_v = 1; mem_delay = 0; pc_reg = 32'h0;
        adv_cycles.delete();
        adv0 = adv_cnt;
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
        run_until_drained(30);
        check("zw_adv_count", adv_cnt - adv0, 3);
        if (adv_cycles.size() >= 3) begin
            check("zw_gap1", adv_cycles[1] - adv_cycles[0], 3);
            check("zw_gap2", adv_cycles[2] - adv_cycles[1], 3);
        end

        // Ack delayed three cycles: request held four
        cyc();
        mem_delay = 3; pc_reg = 32'h40;
        push_exp(32'h40);
        run_until_drained(20);
        check("delay_req_len", last_req_len, 4);
        check("delay_no_err", fetch_err, 0);

        // Decode stalls five cycles in HOLD
        cyc();
        rdy_v = 0; mem_delay = 1; pc_reg = 32'h80;
        push_exp(32'h80);
        n = 0;
        do begin cyc(); n++; end while (!instr_valid && (n < 10));
        check("hold_reached", instr_valid, 1);
        adv0 = adv_cnt;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("hold_valid", instr_valid, 1);
            check("hold_no_req", mem_bus.mem_req, 0);
            check("hold_no_adv", adv_cnt - adv0, 0);
        end
        rdy_v = 1;
        cyc();
        for (int i = 0; i < 3; i++) cyc();
        check("hold_single_adv", adv_cnt - adv0, 1);
        check("hold_drained", sb_q.size(), 0);

        // Flush during REQ, ack two cycles later
        mem_delay = 3; pc_reg = 32'hC0; pv_force = 1;
        wait_req(5);
        pv_force = 0; flush_v = 1;
        cyc();
        flush_v = 0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("drain_req_held", mem_bus.mem_req, 1);
            check("drain_no_valid", instr_valid, 0);
        end
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("post_drain_valid", instr_valid, 0);
            check("post_drain_req", mem_bus.mem_req, 0);
        end

        // Flush together with ready in HOLD
        rdy_v = 0; mem_delay = 0; pc_reg = 32'h100;
        push_exp(32'h100);
        n = 0;
        do begin cyc(); n++; end while (!instr_valid && (n < 10));
        check("fhold_reached", instr_valid, 1);
        adv0 = adv_cnt;
        rdy_v = 1; flush_v = 1;
        cyc();
        flush_v = 0;
        check("fhold_no_adv", adv_cnt - adv0, 0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("fhold_valid_low", instr_valid, 0);
            check("fhold_req_low", mem_bus.mem_req, 0);
        end

        // Ack on the MAX_WAIT-th cycle wins over the timeout
        mem_delay = 15; pc_reg = 32'h300;
        push_exp(32'h300);
        run_until_drained(40);
        check("edge_req_len", last_req_len, 16);
        check("edge_no_err", fetch_err, 0);

        // Reset in the middle of a request
        mem_hang = 1; pc_reg = 32'h500; pv_force = 1;
        wait_req(5);
        cyc(); cyc();
        pv_force = 0;
        pulse_reset();
        check_all_zero("rst_mid_req");
        mem_hang = 0;
        cyc();
        check("rst_stays_idle", mem_bus.mem_req, 0);

        // Misaligned PC
        pc_reg = 32'h6; pv_force = 1;
        n = 0;
        do begin
            cyc();
            check("mis_no_req", mem_bus.mem_req, 0);
            n++;
        end while (!fetch_err && (n < 5));
        check("mis_err", fetch_err, 1);
        check("mis_code", err_code, 2'b01);
        flush_v = 1;
        cyc();
        flush_v = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("mis_sticky", fetch_err, 1);
            check("mis_sticky_code", err_code, 2'b01);
            check("mis_sticky_req", mem_bus.mem_req, 0);
            check("mis_sticky_valid", instr_valid, 0);
        end
        pv_force = 0;
        pulse_reset();
        check("mis_rst_err", fetch_err, 0);
        check("mis_rst_code", err_code, 0);

        // Memory never acks: timeout on the 16th request cycle
        mem_hang = 1; pc_reg = 32'h200; pv_force = 1;
        reqc = 0; n = 0;
        do begin
            cyc();
            if (mem_bus.mem_req) reqc++;
            n++;
        end while (!fetch_err && (n < 40));
        check("to_req_cycles", reqc, 16);
        check("to_err", fetch_err, 1);
        check("to_code", err_code, 2'b10);
        check("to_req_low", mem_bus.mem_req, 0);
        cyc();
        check("to_req_stays_low", mem_bus.mem_req, 0);
        pv_force = 0; mem_hang = 0;
        pulse_reset();
        check("to_rst_err", fetch_err, 0);

        // Normal fetch after recovery
        mem_delay = 1; pc_reg = 32'h600; rdy_v = 1;
        adv0 = adv_cnt;
        push_exp(32'h600);
        run_until_drained(20);
        check("recover_adv", adv_cnt - adv0, 1);
        check("recover_no_err", fetch_err, 0);
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-fetch sequencer for the KGP-RISC core, at the consuming end of the program-counter interface. Takes the current PC, issues a word read to instruction memory over a req/ack handshake, registers the returned instruction with its PC, and presents it to decode on a valid/ready handshake. Generates the PC-advance enable only when decode accepts an instruction. Also handles flush, misalignment and memory timeout.

## Interface
- MAX_WAIT, 16: cycles mem_req may stay unacknowledged before timeout (≥2)
- ADDR_W, 32: PC / memory address width
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- pc_in  in  ADDR_W  current PC from the PC register
- pc_valid  in  1  pc_in holds a fetchable address
- pc_adv  out  1  PC enable; PC loads its next value at this edge
- mem_req  out  1  read request, level, held until mem_ack
- mem_addr  out  ADDR_W  read address, stable while mem_req=1
- mem_ack  in  1  mem_rdata valid this cycle; ends the request
- mem_rdata  in  32  instruction word
- instr_valid  out  1  instr_out/instr_pc valid
- instr_ready  in  1  decode accepts the instruction
- instr_out  out  32  fetched instruction
- instr_pc  out  ADDR_W  address it was fetched from
- flush  in  1  discard current fetch (branch/jump taken)
- fetch_err  out  1  sticky error flag
- err_code  out  2  01 misaligned, 10 timeout, 00 none

## Operation
- States: IDLE, REQ, DRAIN, HOLD, ERR. Reset → IDLE; every output 0.
- IDLE: pc_valid=1 and pc_in[1:0]=00 → latch pc_in into mem_addr, go REQ. pc_valid=1 and pc_in[1:0]≠00 → ERR, err_code=01. Otherwise stay.
- REQ: mem_req=1. mem_ack=1 → register mem_rdata into instr_out and mem_addr into instr_pc, go HOLD. flush=1 without ack → DRAIN. flush=1 with ack → data discarded, go IDLE.
- DRAIN: mem_req stays 1 (requests cannot be withdrawn). mem_ack=1 → discard data, go IDLE.
- HOLD: instr_valid=1, instr_out and instr_pc stable. instr_ready=1 and flush=0 → pc_adv=1 (combinational, same cycle), go IDLE. flush=1 → go IDLE, pc_adv=0 (flush wins over instr_ready).
- Wait counter: cleared on entry to REQ; increments each cycle in REQ/DRAIN without mem_ack. When the count reaches MAX_WAIT → ERR, err_code=10.
- ERR: mem_req=0, instr_valid=0, pc_adv=0. fetch_err=1. Leaves only on rst.
- flush in IDLE or ERR has no effect.
- rst in any state, including mid-request: next cycle IDLE, all outputs 0. Memory must tolerate a dropped req.

## Timing
- mem_req rises one cycle after IDLE samples a valid aligned PC.
- With mem_ack in cycle N, instr_valid=1 from cycle N+1.
- pc_adv is asserted only in a cycle where instr_valid & instr_ready & !flush. The updated PC is sampled in the next IDLE cycle.
- Zero-wait memory (ack in the first REQ cycle) gives 1 instruction every 3 cycles: IDLE, REQ, HOLD.
- Timeout is declared on the MAX_WAIT-th consecutive unacknowledged cycle. An ack in that same cycle takes priority over the timeout.

## Structure
- Shared package kgp_fetch_pkg holds the state enum, the err_code constants (ERR_NONE, ERR_MISALIGN, ERR_TIMEOUT), and the default MAX_WAIT.
- One sub-module, fetch_wait_timer, with clear/enable/expired outputs and a width of $clog2(MAX_WAIT+1). The FSM and output registers stay in instr_fetch_unit.

## Test plan
- Zero-wait memory returning PC+0x100 for each word; PC 0,4,8 with instr_ready=1. Expect instr_pc=0,4,8 and instr_out=0x100,0x104,0x108, one pc_adv pulse per instruction, 3-cycle spacing.
- mem_ack delayed 3 cycles. Expect mem_addr stable and mem_req held for 4 cycles, then instr_valid for one fetch, no error.
- instr_ready=0 for 5 cycles in HOLD. Expect instr_out held, pc_adv=0, no new mem_req. Then ready=1 gives a single pc_adv.
- Flush in REQ with ack arriving 2 cycles later. Expect DRAIN with mem_req held, data not presented, instr_valid never 1. Flush plus ready in HOLD: pc_adv=0.
- pc_in=0x6. Expect ERR, fetch_err=1, err_code=01, mem_req never asserted. Recovers only after rst.
- mem_ack never asserted, MAX_WAIT=16. Expect fetch_err=1 and err_code=10 on the 16th REQ cycle, mem_req=0 after. rst mid-REQ in another run: next cycle IDLE, all outputs 0.
